// File: rtl/usart_cmd_responder.sv
// rtl/usart_cmd_responder.sv - executes decoded USART packets on the register bus and returns one response each
// Optional WAIT_ACK watchdog is enabled by defining USART_RESPONDER_TIMEOUT_EN.
module usart_cmd_responder #(
  parameter int MSG_LENGTH     = 48,
  parameter int DATA_LENGTH    = 32,
  parameter int ADDRWIDTH      = 8,
  parameter int COMMAND_WIDTH  = 5,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     packet_received,
  input  logic [COMMAND_WIDTH-1:0] command,
  input  logic [ADDRWIDTH-1:0]     reg_addr,
  input  logic [DATA_LENGTH-1:0]   rx_data,
  output logic                     send_data,
  output logic [MSG_LENGTH-1:0]    tx_data,
  input  logic                     data_sent,
  output logic                     reg_wr_en,
  output logic                     reg_rd_en,
  output logic [ADDRWIDTH-1:0]     reg_addr_o,
  output logic [DATA_LENGTH-1:0]   reg_wdata,
  input  logic [DATA_LENGTH-1:0]   reg_rdata,
  output logic                     busy,
  output logic [7:0]               drop_count,
  output logic                     timeout_flag
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_DECODE   = 3'd1;
  localparam logic [2:0] S_RD_WAIT  = 3'd2;
  localparam logic [2:0] S_SEND     = 3'd3;
  localparam logic [2:0] S_WAIT_ACK = 3'd4;

  localparam logic [COMMAND_WIDTH-1:0] CMD_WRITE = COMMAND_WIDTH'(1);
  localparam logic [COMMAND_WIDTH-1:0] CMD_READ  = COMMAND_WIDTH'(2);
  localparam logic [COMMAND_WIDTH-1:0] CMD_ECHO  = COMMAND_WIDTH'(3);

  localparam logic [2:0] ST_OK  = 3'b000;
  localparam logic [2:0] ST_BAD = 3'b001;
  localparam logic [2:0] ST_OVR = 3'b010;

  logic [2:0]               state;
  logic [COMMAND_WIDTH-1:0] cur_cmd, pend_cmd, ld_cmd;
  logic [ADDRWIDTH-1:0]     cur_addr, pend_addr, ld_addr;
  logic [DATA_LENGTH-1:0]   cur_data, pend_data, ld_data;
  logic                     pend_valid;
  logic                     overrun;
  logic                     take;
  logic                     wd_expire;
  logic [2:0]               ok_status;

  // The pending entry always has priority over a packet arriving in the same IDLE cycle.
  always_comb begin
    ld_cmd    = pend_valid ? pend_cmd  : command;
    ld_addr   = pend_valid ? pend_addr : reg_addr;
    ld_data   = pend_valid ? pend_data : rx_data;
    take      = (state == S_IDLE) && (pend_valid || packet_received);
    ok_status = overrun ? ST_OVR : ST_OK;
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cur_cmd    <= '0;
      cur_addr   <= '0;
      cur_data   <= '0;
      pend_valid <= 1'b0;
      pend_cmd   <= '0;
      pend_addr  <= '0;
      pend_data  <= '0;
      overrun    <= 1'b0;
      drop_count <= '0;
      send_data  <= 1'b0;
      tx_data    <= '0;
      reg_wr_en  <= 1'b0;
      reg_rd_en  <= 1'b0;
      reg_addr_o <= '0;
      reg_wdata  <= '0;
    end else begin
      send_data <= 1'b0;
      reg_wr_en <= 1'b0;
      reg_rd_en <= 1'b0;

      // Strobes are registered on entry to the state they belong to.
      case (state)
        S_IDLE: begin
          if (take) begin
            cur_cmd   <= ld_cmd;
            cur_addr  <= ld_addr;
            cur_data  <= ld_data;
            reg_wr_en <= (ld_cmd == CMD_WRITE);
            reg_rd_en <= (ld_cmd == CMD_READ);
            if (ld_cmd == CMD_WRITE || ld_cmd == CMD_READ) reg_addr_o <= ld_addr;
            if (ld_cmd == CMD_WRITE) reg_wdata <= ld_data;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          case (cur_cmd)
            CMD_READ: state <= S_RD_WAIT;
            CMD_WRITE, CMD_ECHO: begin
              tx_data   <= {cur_cmd, ok_status, cur_addr, cur_data};
              send_data <= 1'b1;
              overrun   <= 1'b0;
              state     <= S_SEND;
            end
            default: begin
              tx_data   <= {cur_cmd, ST_BAD, cur_addr, {DATA_LENGTH{1'b0}}};
              send_data <= 1'b1;
              overrun   <= 1'b0;
              state     <= S_SEND;
            end
          endcase
        end
        S_RD_WAIT: begin
          tx_data   <= {cur_cmd, ok_status, cur_addr, reg_rdata};
          send_data <= 1'b1;
          overrun   <= 1'b0;
          state     <= S_SEND;
        end
        S_SEND:     state <= S_WAIT_ACK;
        S_WAIT_ACK: if (data_sent || wd_expire) state <= S_IDLE;
        default:    state <= S_IDLE;
      endcase

      // A drop on the edge a response enters SEND is reported on the following response.
      if (packet_received) begin
        if (state == S_IDLE) begin
          if (pend_valid) begin
            pend_cmd  <= command;
            pend_addr <= reg_addr;
            pend_data <= rx_data;
          end
        end else if (!pend_valid) begin
          pend_valid <= 1'b1;
          pend_cmd   <= command;
          pend_addr  <= reg_addr;
          pend_data  <= rx_data;
        end else begin
          overrun <= 1'b1;
          if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
        end
      end else if (state == S_IDLE && pend_valid) begin
        pend_valid <= 1'b0;
      end
    end
  end

`ifdef USART_RESPONDER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [WD_W-1:0] wd_cnt;

  assign wd_expire = (state == S_WAIT_ACK) && !data_sent &&
                     (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt       <= '0;
      timeout_flag <= 1'b0;
    end else begin
      if (state == S_WAIT_ACK) wd_cnt <= wd_cnt + WD_W'(1);
      else                     wd_cnt <= '0;
      if (wd_expire) timeout_flag <= 1'b1;
    end
  end
`else
  assign wd_expire    = 1'b0;
  assign timeout_flag = 1'b0 & (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_usart_cmd_responder.sv
// tb/tb_usart_cmd_responder.sv - scoreboard bench for usart_cmd_responder with a transaction-level model
module tb_usart_cmd_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        packet_received = 1'b0;
  logic [4:0]  command = '0;
  logic [7:0]  reg_addr = '0;
  logic [31:0] rx_data = '0;
  logic        send_data;
  logic [47:0] tx_data;
  logic        data_sent = 1'b0;
  logic        reg_wr_en, reg_rd_en;
  logic [7:0]  reg_addr_o;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata = '0;
  logic        busy;
  logic [7:0]  drop_count;
  logic        timeout_flag;

  usart_cmd_responder #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .packet_received(packet_received), .command(command),
    .reg_addr(reg_addr), .rx_data(rx_data), .send_data(send_data), .tx_data(tx_data),
    .data_sent(data_sent), .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en),
    .reg_addr_o(reg_addr_o), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .busy(busy), .drop_count(drop_count), .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [47:0] tx; int cyc; } resp_t;
  typedef struct { bit wr; logic [7:0] a; logic [31:0] d; int cyc; } bus_t;
  resp_t exp_q[$];
  bus_t  bus_q[$];

  logic [31:0] model_mem [256];
  logic [31:0] bus_mem   [256];
  int  errors = 0, checks = 0;
  int  model_drops = 0;
  bit  model_tflag = 0;
  bit  suppress_ack = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_pkt(input logic [4:0] c, input logic [7:0] a, input logic [31:0] d,
                          input bit ovr, input int rc, input int bc);
    resp_t r;
    bus_t  b;
    logic [2:0] st;
    st = ovr ? 3'b010 : 3'b000;
    b.a = a; b.d = d; b.cyc = bc; b.wr = 1'b0;
    case (c)
      5'h01: begin model_mem[a] = d; r.tx = {c, st, a, d}; b.wr = 1'b1; bus_q.push_back(b); end
      5'h02: begin r.tx = {c, st, a, model_mem[a]}; b.d = '0; bus_q.push_back(b); end
      5'h03: r.tx = {c, st, a, d};
      default: r.tx = {c, 3'b001, a, 32'h0};
    endcase
    r.cyc = rc;
    exp_q.push_back(r);
  endtask

  task automatic drive_pkt(input logic [4:0] c, input logic [7:0] a, input logic [31:0] d);
    packet_received = 1'b1; command = c; reg_addr = a; rx_data = d;
    @(posedge clk); #1;
    packet_received = 1'b0;
  endtask

  task automatic issue(input logic [4:0] c, input logic [7:0] a, input logic [31:0] d,
                       input bit ovr, input bit timed);
    int c0;
    c0 = cyc;
    if (timed) push_pkt(c, a, d, ovr, (c == 5'h02) ? c0 + 3 : c0 + 2, c0 + 1);
    else       push_pkt(c, a, d, ovr, -1, -1);
    drive_pkt(c, a, d);
  endtask

  task automatic wait_quiet();
    int t;
    for (t = 0; t < 300 && (exp_q.size() != 0 || bus_q.size() != 0); t++) @(negedge clk);
    if (t >= 300) chk("quiet_timeout", 64'(exp_q.size() + bus_q.size()), 64'd0);
    repeat (14) @(posedge clk);
    #1;
  endtask

  task automatic wait_send();
    int t;
    for (t = 0; t < 10 && !send_data; t++) @(negedge clk);
    if (t >= 10) chk("send_timeout", 64'(send_data), 64'd1);
  endtask

  function automatic logic [4:0] rand_cmd();
    int s, v;
    s = $urandom_range(0, 3);
    if (s < 3) return 5'(s + 1);
    v = $urandom_range(4, 32);
    return (v == 32) ? 5'h00 : 5'(v);
  endfunction

  // Response monitor
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      if (send_data) begin
        if (exp_q.size() == 0) chk("unexpected_send", {16'h0, tx_data}, 64'h0);
        else begin
          e = exp_q.pop_front();
          chk("tx_data", {16'h0, tx_data}, {16'h0, e.tx});
          if (e.cyc >= 0) chk("send_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  // Register bus monitor and memory; read data is valid only in the cycle after reg_rd_en
  initial begin
    bus_t b;
    bit   rd_pend;
    logic [7:0] rd_a;
    rd_pend = 0; rd_a = '0;
    forever begin
      @(posedge clk); #1;
      reg_rdata = rd_pend ? bus_mem[rd_a] : $urandom;
      rd_pend = 0;
      @(negedge clk);
      if (reg_wr_en || reg_rd_en) begin
        if (bus_q.size() == 0) chk("unexpected_strobe", {reg_wr_en, reg_rd_en, reg_addr_o}, 64'h0);
        else begin
          b = bus_q.pop_front();
          chk("strobe_kind", {reg_wr_en, reg_rd_en}, {b.wr, !b.wr});
          chk("bus_addr", 64'(reg_addr_o), 64'(b.a));
          if (b.wr) chk("bus_wdata", 64'(reg_wdata), 64'(b.d));
          if (b.cyc >= 0) chk("strobe_cycle", 64'(cyc), 64'(b.cyc));
        end
        if (reg_wr_en) bus_mem[reg_addr_o] = reg_wdata;
        if (reg_rd_en) begin rd_pend = 1; rd_a = reg_addr_o; end
      end
    end
  end

  // Link acknowledger
  initial begin
    logic [47:0] cap;
    int d;
    forever begin
      @(negedge clk);
      if (send_data && !suppress_ack) begin
        cap = tx_data;
        d = $urandom_range(6, 10);
        repeat (d) @(posedge clk);
        #1;
        chk("tx_hold", {16'h0, tx_data}, {16'h0, cap});
        data_sent = 1'b1;
        @(posedge clk); #1;
        data_sent = 1'b0;
        @(negedge clk);
        chk("busy_after_ack", 64'(busy), 64'd0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [4:0] c1;
    logic [7:0] a1;
    logic [31:0] d1;
    int extras;

    for (int i = 0; i < 256; i++) begin
      model_mem[i] = $urandom;
      bus_mem[i]   = model_mem[i];
    end
    model_mem[4] = 32'h12345678;
    bus_mem[4]   = 32'h12345678;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_send_data", 64'(send_data), 64'd0);
    chk("rst_tx_data", {16'h0, tx_data}, 64'd0);
    chk("rst_strobes", {reg_wr_en, reg_rd_en}, 64'd0);
    chk("rst_addr_wdata", {reg_addr_o, reg_wdata}, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_drop_count", 64'(drop_count), 64'd0);
    chk("rst_timeout", 64'(timeout_flag), 64'd0);
    @(posedge clk); #1;

    issue(5'h01, 8'h10, 32'hDEADBEEF, 0, 1);
    wait_quiet();
    issue(5'h02, 8'h04, 32'h0, 0, 1);
    wait_quiet();
    issue(5'h1F, 8'h22, 32'hCAFEF00D, 0, 1);
    wait_quiet();

    // Overrun: three back-to-back packets while the first waits for its ack
    issue(5'h03, 8'h01, 32'h11111111, 0, 1);
    wait_send();
    @(posedge clk); #1;
    issue(5'h03, 8'h02, 32'h22222222, 0, 0);
    issue(5'h01, 8'h03, 32'h33333333, 1, 0);
    model_mem[3] = bus_mem[3];
    void'(exp_q.pop_back());
    void'(bus_q.pop_back());
    model_drops++;
    issue(5'h03, 8'h04, 32'h44444444, 0, 0);
    void'(exp_q.pop_back());
    model_drops++;
    exp_q[exp_q.size()-1].tx[42:40] = 3'b010;
    wait_quiet();
    chk("overrun_drop_count", 64'(drop_count), 64'(model_drops));

    // Reset while the read is waiting for register data
    begin
      bus_t b;
      int c0;
      c0 = cyc;
      b.wr = 1'b0; b.a = 8'h04; b.d = '0; b.cyc = c0 + 1;
      bus_q.push_back(b);
      drive_pkt(5'h02, 8'h04, 32'h0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      model_drops = 0;
      @(negedge clk);
      chk("mid_rst_outputs", {send_data, reg_wr_en, reg_rd_en, busy, drop_count}, 64'd0);
      chk("mid_rst_tx_data", {16'h0, tx_data}, 64'd0);
      @(posedge clk); #1;
      issue(5'h03, 8'h5A, 32'h0BADCAFE, 0, 1);
      wait_quiet();
    end

`ifdef USART_RESPONDER_TIMEOUT_EN
    suppress_ack = 1;
    issue(5'h03, 8'h77, 32'h76543210, 0, 1);
    repeat (40) @(posedge clk);
    #1;
    chk("timeout_idle", 64'(busy), 64'd0);
    chk("timeout_flag_set", 64'(timeout_flag), 64'd1);
    model_tflag = 1;
    suppress_ack = 0;
    issue(5'h03, 8'h78, 32'h89ABCDEF, 0, 1);
    wait_quiet();
`endif

    for (int b = 0; b < 260; b++) begin
      c1 = rand_cmd();
      a1 = 8'($urandom_range(0, 15));
      d1 = $urandom;
      issue(c1, a1, d1, 0, 1);
      extras = $urandom_range(0, 4);
      if (extras > 0) begin
        wait_send();
        @(posedge clk); #1;
        issue(rand_cmd(), 8'($urandom_range(0, 15)), $urandom, extras >= 2, 0);
        for (int k = 2; k <= extras; k++) begin
          drive_pkt(rand_cmd(), 8'($urandom_range(0, 15)), $urandom);
          if (model_drops < 255) model_drops++;
        end
      end
      wait_quiet();
      chk("drop_count", 64'(drop_count), 64'(model_drops));
    end

    chk("final_timeout_flag", 64'(timeout_flag), 64'(model_tflag));
    chk("final_busy", 64'(busy), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/usart_cmd_responder.md
Name: usart_cmd_responder

Overview:
- Command-execution end of the USART manager link. Consumes decoded packets (packet_received, command, reg_addr, rx_data).
- Performs register writes and reads on a simple register bus. Returns one 48-bit response per packet through send_data/tx_data, waiting for data_sent.
- Sits between the USART manager and the DAQ register file.
- Includes a one-entry pending slot so that back-to-back packets are not lost.

Parameters:
- MSG_LENGTH, 48, response message width; must equal COMMAND_WIDTH+3+ADDRWIDTH+DATA_LENGTH
- DATA_LENGTH, 32, register data width
- ADDRWIDTH, 8, register address width
- COMMAND_WIDTH, 5, command field width
- TIMEOUT_CYCLES, 1024, WAIT_ACK watchdog limit; used only with the optional feature

Ports:
- clk  in  1  single system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- packet_received  in  1  one-cycle pulse; command/reg_addr/rx_data valid in that cycle
- command  in  COMMAND_WIDTH  packet command
- reg_addr  in  ADDRWIDTH  packet register address
- rx_data  in  DATA_LENGTH  packet payload
- send_data  out  1  one-cycle request to transmit tx_data
- tx_data  out  MSG_LENGTH  response {cmd[4:0], status[2:0], addr[7:0], data[31:0]}
- data_sent  in  1  one-cycle pulse: response transmitted
- reg_wr_en  out  1  register write strobe
- reg_rd_en  out  1  register read strobe
- reg_addr_o  out  ADDRWIDTH  register bus address
- reg_wdata  out  DATA_LENGTH  register write data
- reg_rdata  in  DATA_LENGTH  read data, valid exactly 1 cycle after reg_rd_en
- busy  out  1  high whenever FSM is not IDLE
- drop_count  out  8  saturating count of dropped packets
- timeout_flag  out  1  sticky watchdog flag; constant 0 without the optional feature

Behaviour:
- Reset: all outputs are 0, FSM is IDLE, the pending slot is empty, and the latched cmd/addr/data are 0.
- Commands:
  - 5'h01 WRITE
  - 5'h02 READ
  - 5'h03 ECHO
  - all other values are BAD_CMD
- Status codes: 3'b000 OK, 3'b001 BAD_CMD, 3'b010 OVERRUN (set on a response when one or more packets were dropped since the previous response).
- FSM states:
  - IDLE: if the pending slot is valid, load it and clear it; otherwise, on packet_received, latch the inputs. Either case goes to DECODE.
  - DECODE (1 cycle):
    - WRITE: reg_wr_en=1, reg_addr_o=addr, reg_wdata=data; response data=data; go to SEND.
    - READ: reg_rd_en=1, reg_addr_o=addr; go to RD_WAIT.
    - ECHO: response data=data; go to SEND.
    - BAD_CMD: response data=0, status BAD_CMD, no bus strobe; go to SEND.
  - RD_WAIT (1 cycle): capture reg_rdata as response data; go to SEND.
  - SEND (1 cycle): send_data=1 and tx_data is driven; go to WAIT_ACK.
  - WAIT_ACK: on data_sent go to IDLE; tx_data holds stable until then.
- Strobes: reg_wr_en, reg_rd_en and send_data are registered and high for exactly one cycle per packet.
- Latency, with the packet sampled at edge N:
  - WRITE: reg_wr_en high in cycle N+1, send_data high in N+2.
  - READ: reg_rd_en high in N+1, reg_rdata sampled at end of N+2, send_data high in N+3.
- tx_data holds its last value after data_sent until the next SEND.
- packet_received while not IDLE:
  - Stored in the pending slot if the slot is empty.
  - If the slot is full, the packet is dropped: drop_count increments, saturating at 255, and the OVERRUN status flag is set.
- packet_received in IDLE while the pending slot is valid: the pending entry is served first; the new packet goes into the freed slot.
- packet_received and data_sent in the same WAIT_ACK cycle: the packet goes to the pending slot; the FSM goes to IDLE, then to DECODE on the next edge.
- data_sent outside WAIT_ACK is ignored.
- OVERRUN handling: the flag is reported in the next response's status (overriding OK, not BAD_CMD) and is cleared when that response enters SEND. drop_count is cleared only by reset.
- reset mid-operation: the FSM returns to IDLE immediately, no strobe is emitted on the reset cycle, the pending slot is cleared, and the in-flight response is abandoned.

Optional Feature:
- Macro: USART_RESPONDER_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_ACK.
  - If data_sent has not arrived after TIMEOUT_CYCLES cycles, the FSM returns to IDLE and sets timeout_flag.
  - timeout_flag is sticky and is cleared only by reset.
- Undefined: there is no counter, WAIT_ACK waits indefinitely, and timeout_flag is tied to 0.

Test Plan:
- WRITE: cmd=01, addr=0x10, data=0xDEADBEEF; data_sent 5 cycles after send_data.
  - reg_wr_en high 1 cycle with addr 0x10 / 0xDEADBEEF.
  - tx_data = {01,000,10,DEADBEEF}.
  - busy drops the cycle after data_sent.
- READ: cmd=02, addr=0x04, reg_rdata=0x12345678 one cycle after reg_rd_en.
  - send_data at N+3.
  - tx_data = {02,000,04,12345678}.
- BAD_CMD: cmd=1F → no reg strobes; tx_data = {1F,001,addr,00000000}.
- Overrun: three packets back-to-back while the first is in WAIT_ACK.
  - The second is served after data_sent; the third is dropped.
  - drop_count=1; the second response status = 010.
- Reset asserted in RD_WAIT → next cycle all outputs 0, pending empty; a following ECHO completes normally.
- With USART_RESPONDER_TIMEOUT_EN and TIMEOUT_CYCLES=16, withhold data_sent → IDLE after 16 cycles, timeout_flag=1; the next packet is processed.
